// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and a
// ceiling-log2 helper used to size the bit counter.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Combinational one-bit full adder cell.
// Ports: a, b, cin - addend bits and carry-in
//        sum, carry - sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in LSB-first, one
// bit per clock, through a single full_adder cell with a registered carry.
// Ports: clk, rst (synchronous, active-high)
//        in_valid/in_ready, a_in, b_in, cin      - operand handshake
//        out_valid/out_ready, sum_out, cout_out,
//        ovf_out                                 - result handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int unsigned CntW = clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  s_sh_q, s_sh_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic fa_sum;
  logic fa_carry;

  full_adder u_full_adder (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Held low while rst is high so nothing is advertised during reset.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign sum_out   = sum_q;
  assign cout_out  = cout_q;
  assign ovf_out   = ovf_q;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // Result registers hold the value past the handshake, so they are
          // loaded here. Overflow is the carry into the MSB (carry_q, before
          // update) XOR the carry out of it.
          sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder with WIDTH=8.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum_out;
  logic       cout_out;
  logic       ovf_out;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .ovf_out   (ovf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand set, returns cycles from accept edge to out_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    a_in     = a;
    b_in     = b;
    cin      = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
    checks++;
    if (sum_out !== 8'h00 || cout_out !== 1'b0 || ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b want 00/0/0", sum_out, cout_out, ovf_out);
    end
  endtask

  task automatic test_zero();
    int lat;
    run_op(8'h00, 8'h00, 1'b0, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL zero_latency: got %0d want 8", lat);
    end
    checks++;
    if (sum_out !== 8'h00 || cout_out !== 1'b0 || ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: got %h/%b/%b want 00/0/0", sum_out, cout_out, ovf_out);
    end
    consume();
  endtask

  task automatic test_carry_ovf();
    int lat;
    run_op(8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if (sum_out !== 8'h00 || cout_out !== 1'b1 || ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL ff_plus_1: got %h/%b/%b want 00/1/0", sum_out, cout_out, ovf_out);
    end
    consume();
    run_op(8'h7F, 8'h01, 1'b0, lat);
    checks++;
    if (sum_out !== 8'h80 || cout_out !== 1'b0 || ovf_out !== 1'b1) begin
      errors++;
      $display("FAIL 7f_plus_1: got %h/%b/%b want 80/0/1", sum_out, cout_out, ovf_out);
    end
    consume();
  endtask

  task automatic test_mixed();
    int lat;
    run_op(8'hA5, 8'h5A, 1'b1, lat);
    checks++;
    if (sum_out !== 8'h00 || cout_out !== 1'b1 || ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL a5_5a_c1: got %h/%b/%b want 00/1/0", sum_out, cout_out, ovf_out);
    end
    consume();
    run_op(8'h80, 8'h80, 1'b0, lat);
    checks++;
    if (sum_out !== 8'h00 || cout_out !== 1'b1 || ovf_out !== 1'b1) begin
      errors++;
      $display("FAIL 80_80: got %h/%b/%b want 00/1/1", sum_out, cout_out, ovf_out);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL 80_80_latency: got %0d want 8", lat);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(8'h33, 8'h11, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a_in     = 8'(i * 17 + 3);
      tick();
      checks++;
      if (out_valid !== 1'b1 || sum_out !== 8'h44 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got v=%b sum=%h rdy=%b want 1/44/0",
                 i, out_valid, sum_out, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (sum_out !== 8'h44) begin
      errors++;
      $display("FAIL result_retained: got %h want 44", sum_out);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    logic [7:0] res[2];
    int n_acc;
    int n_res;
    logic acc;
    n_acc = 0;
    n_res = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    res[0] = 8'hxx;
    res[1] = 8'hxx;
    a_in      = 8'h12;
    b_in      = 8'h34;
    cin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 40 && n_res < 2; cyc++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          a_in = 8'h0F;
          b_in = 8'h01;
          cin  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && n_res < 2) begin
        res[n_res] = sum_out;
        n_res++;
      end
    end
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (res[0] !== 8'h46) begin
      errors++;
      $display("FAIL b2b_first: got %h want 46", res[0]);
    end
    checks++;
    if (res[1] !== 8'h11) begin
      errors++;
      $display("FAIL b2b_second: got %h want 11", res[1]);
    end
    checks++;
    if (n_acc !== 2 || (acc_cyc[1] - acc_cyc[0]) !== 10) begin
      errors++;
      $display("FAIL b2b_spacing: got accepts=%0d gap=%0d want 2/10",
               n_acc, acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    a_in     = 8'hFF;
    b_in     = 8'hFF;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum_out !== 8'h00 || cout_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b v=%b sum=%h cout=%b want 1/0/00/0",
               in_ready, out_valid, sum_out, cout_out);
    end
    run_op(8'h20, 8'h22, 1'b0, lat);
    checks++;
    if (sum_out !== 8'h42 || cout_out !== 1'b0 || lat !== 8) begin
      errors++;
      $display("FAIL after_reset_op: got sum=%h cout=%b lat=%0d want 42/0/8",
               sum_out, cout_out, lat);
    end
    consume();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = 8'h00;
    b_in      = 8'h00;
    cin       = 1'b0;
    test_reset();
    test_zero();
    test_carry_ovf();
    test_mixed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
